// File: rtl/mc_pkg.sv
// Shared constants and instruction field decode for the multicycle datapath and controller.
package mc_pkg;

  localparam logic [2:0] ALU_AND = 3'd0;
  localparam logic [2:0] ALU_OR  = 3'd1;
  localparam logic [2:0] ALU_ADD = 3'd2;
  localparam logic [2:0] ALU_SUB = 3'd6;
  localparam logic [2:0] ALU_SLT = 3'd7;

  localparam logic [1:0] SRCB_REG  = 2'd0;
  localparam logic [1:0] SRCB_INC  = 2'd1;
  localparam logic [1:0] SRCB_IMM  = 2'd2;
  localparam logic [1:0] SRCB_IMM2 = 2'd3;

  localparam int OP_MSB = 31, OP_LSB = 26;
  localparam int RS_MSB = 25, RS_LSB = 21;
  localparam int RT_MSB = 20, RT_LSB = 16;
  localparam int RD_MSB = 15, RD_LSB = 11;
  localparam int IMM_MSB = 15, IMM_LSB = 0;
  localparam int FN_MSB = 5, FN_LSB = 0;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [5:0]  funct;
  } fields_t;

  function automatic fields_t decode_fields(input logic [31:0] ir);
    fields_t f;
    f.op    = ir[OP_MSB:OP_LSB];
    f.rs    = ir[RS_MSB:RS_LSB];
    f.rt    = ir[RT_MSB:RT_LSB];
    f.rd    = ir[RD_MSB:RD_LSB];
    f.imm   = ir[IMM_MSB:IMM_LSB];
    f.funct = ir[FN_MSB:FN_LSB];
    return f;
  endfunction

endpackage

// File: rtl/mc_datapath_if.sv
// Control word, status, memory port and debug bundle between controller and datapath.
interface mc_datapath_if #(parameter int W = 32);
  logic         PCEn, IorD, Memwrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUsrcA, PCsrc;
  logic [1:0]   ALUsrcB;
  logic [2:0]   ALUControl;
  logic [5:0]   opcode, funct;
  logic         zero;
  logic [W-1:0] mem_addr, mem_wdata, mem_rdata;
  logic         mem_we;
  logic [4:0]   dbg_raddr;
  logic [W-1:0] dbg_rdata, dbg_pc;

  modport master (
    output PCEn, IorD, Memwrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUsrcA, PCsrc,
    output ALUsrcB, ALUControl, mem_rdata, dbg_raddr,
    input  opcode, funct, zero, mem_addr, mem_wdata, mem_we, dbg_rdata, dbg_pc
  );

  modport slave (
    input  PCEn, IorD, Memwrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUsrcA, PCsrc,
    input  ALUsrcB, ALUControl, mem_rdata, dbg_raddr,
    output opcode, funct, zero, mem_addr, mem_wdata, mem_we, dbg_rdata, dbg_pc
  );
endinterface

// File: rtl/mc_regfile.sv
// Register file: two async read ports plus debug read, one sync write, r0 hardwired to zero.
module mc_regfile #(
  parameter int W     = 32,
  parameter int NREGS = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [4:0]   ra1_i,
  input  logic [4:0]   ra2_i,
  input  logic [4:0]   dbg_ra_i,
  input  logic [4:0]   wa_i,
  input  logic         we_i,
  input  logic [W-1:0] wd_i,
  output logic [W-1:0] rd1_o,
  output logic [W-1:0] rd2_o,
  output logic [W-1:0] dbg_rd_o
);

  logic [W-1:0] regs_q [NREGS];

  // Reset clear dominates any write in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= {W{1'b0}};
    end else if (we_i && (wa_i != 5'd0)) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  assign rd1_o    = (ra1_i    == 5'd0) ? {W{1'b0}} : regs_q[ra1_i];
  assign rd2_o    = (ra2_i    == 5'd0) ? {W{1'b0}} : regs_q[ra2_i];
  assign dbg_rd_o = (dbg_ra_i == 5'd0) ? {W{1'b0}} : regs_q[dbg_ra_i];

endmodule

// File: rtl/mc_datapath.sv
// Multicycle datapath: PC, IR, MDR, A, B, ALUOut, register file, ALU and operand muxes.
module mc_datapath
  import mc_pkg::*;
#(
  parameter int           W        = 32,
  parameter logic [W-1:0] RESET_PC = {W{1'b0}},
  parameter logic [W-1:0] PC_INC   = W'(32'd4),
  parameter int           NREGS    = 32
) (
  input logic         clk,
  input logic         rst,
  mc_datapath_if.slave bus
);

  logic [W-1:0] pc_q, pc_d, ir_q, ir_d, mdr_q, mdr_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, aluout_q, aluout_d;
  logic [W-1:0] imm_ext_s, src_a_s, src_b_s, alu_s;
  logic [W-1:0] rf_rd1_s, rf_rd2_s, rf_wd_s;
  logic [4:0]   rf_wa_s;
  fields_t      f_s;

  assign f_s       = decode_fields(ir_q[31:0]);
  assign imm_ext_s = {{(W-16){f_s.imm[15]}}, f_s.imm};
  assign src_a_s   = bus.ALUsrcA ? a_q : pc_q;

  // ALU B operand select
  always_comb begin
    src_b_s = b_q;
    case (bus.ALUsrcB)
      SRCB_REG:  src_b_s = b_q;
      SRCB_INC:  src_b_s = PC_INC;
      SRCB_IMM:  src_b_s = imm_ext_s;
      SRCB_IMM2: src_b_s = {imm_ext_s[W-3:0], 2'b00};
      default:   src_b_s = b_q;
    endcase
  end

  // ALU; unknown operation codes yield zero
  always_comb begin
    alu_s = {W{1'b0}};
    case (bus.ALUControl)
      ALU_ADD: alu_s = src_a_s + src_b_s;
      ALU_SUB: alu_s = src_a_s - src_b_s;
      ALU_AND: alu_s = src_a_s & src_b_s;
      ALU_OR:  alu_s = src_a_s | src_b_s;
      ALU_SLT: alu_s = {{(W-1){1'b0}}, ($signed(src_a_s) < $signed(src_b_s))};
      default: alu_s = {W{1'b0}};
    endcase
  end

  assign rf_wa_s = bus.RegDst   ? f_s.rd : f_s.rt;
  assign rf_wd_s = bus.MemtoReg ? mdr_q  : aluout_q;

  mc_regfile #(.W(W), .NREGS(NREGS)) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .ra1_i    (f_s.rs),
    .ra2_i    (f_s.rt),
    .dbg_ra_i (bus.dbg_raddr),
    .wa_i     (rf_wa_s),
    .we_i     (bus.RegWrite),
    .wd_i     (rf_wd_s),
    .rd1_o    (rf_rd1_s),
    .rd2_o    (rf_rd2_s),
    .dbg_rd_o (bus.dbg_rdata)
  );

  // Next-state for the architectural and staging registers
  always_comb begin
    pc_d     = pc_q;
    ir_d     = ir_q;
    mdr_d    = bus.mem_rdata;
    a_d      = rf_rd1_s;
    b_d      = rf_rd2_s;
    aluout_d = alu_s;
    if (bus.PCEn) pc_d = bus.PCsrc ? aluout_q : alu_s;
    else          pc_d = pc_q;
    if (bus.IRWrite) ir_d = bus.mem_rdata;
    else             ir_d = ir_q;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      ir_q     <= {W{1'b0}};
      mdr_q    <= {W{1'b0}};
      a_q      <= {W{1'b0}};
      b_q      <= {W{1'b0}};
      aluout_q <= {W{1'b0}};
    end else begin
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      mdr_q    <= mdr_d;
      a_q      <= a_d;
      b_q      <= b_d;
      aluout_q <= aluout_d;
    end
  end

  // zero comes from the live ALU result so beq can gate PCEn in the same cycle
  assign bus.zero      = (alu_s == {W{1'b0}});
  assign bus.opcode    = f_s.op;
  assign bus.funct     = f_s.funct;
  assign bus.mem_addr  = bus.IorD ? aluout_q : pc_q;
  assign bus.mem_wdata = b_q;
  assign bus.mem_we    = bus.Memwrite;
  assign bus.dbg_pc    = pc_q;

endmodule

// File: tb/tb_mc_datapath.sv
// Scoreboard bench for mc_datapath: drives control words on negedge, checks after posedge.
module tb_mc_datapath;
  import mc_pkg::*;

  typedef enum int {SEL_IR, SEL_PC, SEL_OP, SEL_FN, SEL_ZERO, SEL_ADDR, SEL_DBG, SEL_WE, SEL_WDATA} sel_e;
  typedef struct {
    string       tag;
    sel_e        sel;
    logic [4:0]  idx;
    logic [31:0] exp;
  } sb_item_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_pc = 32'h0;
  sb_item_t    sb_q[$];

  mc_datapath_if #(.W(32)) bus();

  mc_datapath dut (.clk(clk), .rst(rst), .bus(bus));

  always #10 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] alu_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd2:    return a + b;
      3'd6:    return a - b;
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd7:    return (signed'(a) < signed'(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic push(input string tag, input sel_e sel, input logic [4:0] idx, input logic [31:0] exp);
    sb_item_t it;
    it.tag = tag; it.sel = sel; it.idx = idx; it.exp = exp;
    sb_q.push_back(it);
  endtask

  task automatic drain();
    sb_item_t    it;
    logic [31:0] obs;
    while (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      bus.dbg_raddr = it.idx;
      #1;
      case (it.sel)
        SEL_IR:    obs = dut.ir_q;
        SEL_PC:    obs = bus.dbg_pc;
        SEL_OP:    obs = {26'd0, bus.opcode};
        SEL_FN:    obs = {26'd0, bus.funct};
        SEL_ZERO:  obs = {31'd0, bus.zero};
        SEL_ADDR:  obs = bus.mem_addr;
        SEL_DBG:   obs = bus.dbg_rdata;
        SEL_WE:    obs = {31'd0, bus.mem_we};
        SEL_WDATA: obs = bus.mem_wdata;
        default:   obs = 32'hxxxx_xxxx;
      endcase
      check_val(it.tag, obs, it.exp);
    end
  endtask

  task automatic ctl_begin(input logic [31:0] rdata);
    @(negedge clk);
    bus.PCEn = 1'b0; bus.IorD = 1'b0; bus.Memwrite = 1'b0; bus.IRWrite = 1'b0;
    bus.RegDst = 1'b0; bus.MemtoReg = 1'b0; bus.RegWrite = 1'b0; bus.ALUsrcA = 1'b0;
    bus.PCsrc = 1'b0; bus.ALUsrcB = SRCB_REG; bus.ALUControl = ALU_ADD;
    bus.mem_rdata = rdata;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic do_reset();
    ctl_begin(32'h0);
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_pc = 32'h0;
    push("rst_pc", SEL_PC, 5'd0, 32'h0);
    push("rst_ir", SEL_IR, 5'd0, 32'h0);
    push("rst_opcode", SEL_OP, 5'd0, 32'h0);
    push("rst_funct", SEL_FN, 5'd0, 32'h0);
    push("rst_addr", SEL_ADDR, 5'd0, 32'h0);
    push("rst_r2", SEL_DBG, 5'd2, 32'h0);
    drain();
  endtask

  task automatic fetch(input logic [31:0] instr);
    ctl_begin(instr);
    bus.PCEn = 1'b1; bus.IRWrite = 1'b1; bus.ALUsrcB = SRCB_INC; bus.ALUControl = ALU_ADD;
    push("fetch_addr", SEL_ADDR, 5'd0, exp_pc);
    #1;
    drain();
    exp_pc = exp_pc + 32'd4;
    push("fetch_ir", SEL_IR, 5'd0, instr);
    push("fetch_pc", SEL_PC, 5'd0, exp_pc);
    push("fetch_opcode", SEL_OP, 5'd0, {26'd0, instr[31:26]});
    push("fetch_funct", SEL_FN, 5'd0, {26'd0, instr[5:0]});
    push("fetch_addr_next", SEL_ADDR, 5'd0, exp_pc);
    step();
  endtask

  // Writes val into rf[r] through the MDR path without touching PC
  task automatic load_reg(input logic [4:0] r, input logic [31:0] val);
    ctl_begin({6'h23, 5'd0, r, 16'h0});
    bus.IRWrite = 1'b1;
    step();
    ctl_begin(val);
    step();
    ctl_begin(32'h0);
    bus.MemtoReg = 1'b1; bus.RegWrite = 1'b1;
    push("load_reg", SEL_DBG, r, val);
    step();
  endtask

  task automatic run_rtype(input logic [31:0] instr, input logic [2:0] aluc, input logic [31:0] exp);
    logic [4:0] rd;
    rd = instr[15:11];
    fetch(instr);
    ctl_begin(32'h0);
    bus.ALUsrcB = SRCB_IMM2;
    step();
    ctl_begin(32'h0);
    bus.ALUsrcA = 1'b1; bus.ALUsrcB = SRCB_REG; bus.ALUControl = aluc;
    push("exec_zero", SEL_ZERO, 5'd0, {31'd0, (exp == 32'h0)});
    #1;
    drain();
    step();
    ctl_begin(32'h0);
    bus.RegDst = 1'b1; bus.RegWrite = 1'b1;
    push("wb_rd", SEL_DBG, rd, (rd == 5'd0) ? 32'h0 : exp);
    push("wb_pc", SEL_PC, 5'd0, exp_pc);
    step();
  endtask

  task automatic run_beq(input logic [31:0] a, input logic [31:0] b);
    load_reg(5'd1, a);
    load_reg(5'd2, b);
    fetch(32'h0000_0000);
    fetch(32'h1022_0003);
    ctl_begin(32'h0);
    bus.ALUsrcB = SRCB_IMM2;
    step();
    ctl_begin(32'h0);
    bus.ALUsrcA = 1'b1; bus.ALUControl = ALU_SUB; bus.PCsrc = 1'b1;
    push("beq_zero", SEL_ZERO, 5'd0, {31'd0, (a == b)});
    #1;
    drain();
    bus.PCEn = bus.zero;
    if (a == b) exp_pc = 32'd20;
    else        exp_pc = 32'd8;
    push("beq_pc", SEL_PC, 5'd0, exp_pc);
    step();
  endtask

  // lw r2,4(r1) up to the MDR capture; writeback is left to the caller
  task automatic lw_to_mdr();
    load_reg(5'd1, 32'h0000_0100);
    fetch(32'h8C22_0004);
    ctl_begin(32'h0);
    bus.ALUsrcB = SRCB_IMM2;
    step();
    ctl_begin(32'h0);
    bus.ALUsrcA = 1'b1; bus.ALUsrcB = SRCB_IMM;
    step();
    ctl_begin(32'h0);
    bus.IorD = 1'b1;
    push("lw_addr", SEL_ADDR, 5'd0, 32'h0000_0104);
    #1;
    drain();
    bus.mem_rdata = (bus.mem_addr == 32'h0000_0104) ? 32'hDEAD_BEEF : 32'h0;
    step();
  endtask

  initial begin
    logic [2:0]  ops [5];
    logic [5:0]  fns [5];
    logic [31:0] instr;
    ops = '{ALU_AND, ALU_OR, ALU_SLT, ALU_SUB, 3'd3};
    fns = '{FN_AND, FN_OR, FN_SLT, FN_SUB, 6'h00};
    bus.dbg_raddr = 5'd0;

    do_reset();
    fetch(32'h8C22_0004);

    load_reg(5'd1, 32'd5);
    load_reg(5'd2, 32'd7);
    run_rtype(32'h0022_1820, ALU_ADD, 32'd12);
    for (int i = 0; i < 5; i++) begin
      instr = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, fns[i]};
      run_rtype(instr, ops[i], alu_model(ops[i], 32'd5, 32'd7));
    end

    load_reg(5'd1, 32'd0);
    load_reg(5'd2, 32'd1);
    run_rtype(32'h0022_1822, ALU_SUB, 32'hFFFF_FFFF);
    run_rtype({6'h00, 5'd3, 5'd1, 5'd4, 5'd0, FN_SLT}, ALU_SLT, alu_model(ALU_SLT, 32'hFFFF_FFFF, 32'd0));
    run_rtype({6'h00, 5'd1, 5'd2, 5'd0, 5'd0, FN_ADD}, ALU_ADD, 32'd1);

    lw_to_mdr();
    ctl_begin(32'h0);
    bus.MemtoReg = 1'b1; bus.RegWrite = 1'b1;
    push("lw_r2", SEL_DBG, 5'd2, 32'hDEAD_BEEF);
    step();
    ctl_begin(32'h0);
    step();
    ctl_begin(32'h0);
    bus.Memwrite = 1'b1;
    push("sw_we", SEL_WE, 5'd0, 32'd1);
    push("sw_wdata", SEL_WDATA, 5'd0, 32'hDEAD_BEEF);
    #1;
    drain();
    step();

    do_reset();
    run_beq(32'd9, 32'd9);
    do_reset();
    run_beq(32'd9, 32'd3);

    lw_to_mdr();
    ctl_begin(32'h0);
    bus.MemtoReg = 1'b1; bus.RegWrite = 1'b1; bus.PCEn = 1'b1; bus.IRWrite = 1'b1;
    rst = 1'b1;
    push("rstwb_r2", SEL_DBG, 5'd2, 32'h0);
    push("rstwb_pc", SEL_PC, 5'd0, 32'h0);
    push("rstwb_ir", SEL_IR, 5'd0, 32'h0);
    push("rstwb_opcode", SEL_OP, 5'd0, 32'h0);
    step();
    ctl_begin(32'h0);
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
